// File: rtl/inv_mix_columns_seq_if.sv
// Start/done handshake and state buses between the decrypt round controller
// and the sequential InvMixColumns engine.
interface inv_mix_columns_seq_if;
  logic         start;
  logic [127:0] state_in;
  logic         busy;
  logic         done;
  logic [127:0] state_out;

  modport master (
    output start,
    output state_in,
    input  busy,
    input  done,
    input  state_out
  );

  modport slave (
    input  start,
    input  state_in,
    output busy,
    output done,
    output state_out
  );
endinterface

// File: rtl/inv_mix_columns_seq.sv
// Sequential InvMixColumns: LANES output bytes per cycle through shared
// GF(2^8) constant multipliers, driven from a latched copy of the input state.

module mul_9 (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] x2, x4, x8;
  always_comb begin
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    y  = x8 ^ a;
  end
endmodule

module mul_11 (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] x2, x4, x8;
  always_comb begin
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    y  = x8 ^ x2 ^ a;
  end
endmodule

module mul_13 (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] x2, x4, x8;
  always_comb begin
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    y  = x8 ^ x4 ^ a;
  end
endmodule

module mul_14 (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] x2, x4, x8;
  always_comb begin
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    y  = x8 ^ x4 ^ x2;
  end
endmodule

module inv_mix_columns_seq #(
  parameter int LANES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  inv_mix_columns_seq_if.slave   bus
);
  localparam int STEPS = 16 / LANES;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [127:0]     in_q;
  logic [127:0]     res_q;
  logic [127:0]     res_d;

  logic [7:0] in_bytes  [16];
  logic [3:0] lane_idx  [LANES];
  logic [7:0] lane_byte [LANES];

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_in_bytes
      assign in_bytes[gi] = in_q[127 - 8*gi -: 8];
    end

    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [1:0] row, r1, r2, r3, col;
      logic [7:0] a0, a1, a2, a3;
      logic [7:0] m14, m11, m13, m9;

      assign lane_idx[gi] = 4'(int'(cnt_q) * LANES + gi);
      assign col = lane_idx[gi][3:2];
      assign row = lane_idx[gi][1:0];
      // Row offsets wrap within the column (2-bit arithmetic).
      assign r1  = row + 2'd1;
      assign r2  = row + 2'd2;
      assign r3  = row + 2'd3;

      assign a0 = in_bytes[{col, row}];
      assign a1 = in_bytes[{col, r1}];
      assign a2 = in_bytes[{col, r2}];
      assign a3 = in_bytes[{col, r3}];

      mul_14 u_mul_14 (.a(a0), .y(m14));
      mul_11 u_mul_11 (.a(a1), .y(m11));
      mul_13 u_mul_13 (.a(a2), .y(m13));
      mul_9  u_mul_9  (.a(a3), .y(m9));

      assign lane_byte[gi] = m14 ^ m11 ^ m13 ^ m9;
    end
  endgenerate

  always_comb begin
    res_d = res_q;
    if (state_q == RUN) begin
      for (int l = 0; l < LANES; l++) begin
        res_d[127 - 8*int'(lane_idx[l]) -: 8] = lane_byte[l];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      in_q    <= '0;
      res_q   <= '0;
    end else begin
      res_q <= res_d;
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            in_q    <= bus.state_in;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          // Start is only looked at in IDLE, so a held start restarts one cycle later.
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.state_out = res_q;
endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Directed bench for inv_mix_columns_seq with LANES=1 and LANES=4 instances.
module tb_inv_mix_columns_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inv_mix_columns_seq_if if_l1 ();
  inv_mix_columns_seq_if if_l4 ();

  inv_mix_columns_seq #(.LANES(1)) dut_l1 (.clk(clk), .rst(rst), .bus(if_l1));
  inv_mix_columns_seq #(.LANES(4)) dut_l4 (.clk(clk), .rst(rst), .bus(if_l4));

  localparam logic [127:0] V1_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V1_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V2_IN  = 128'hd5d5d7d6_4d7ebdf8_8e4da1bc_01010101;
  localparam logic [127:0] V2_OUT = 128'hd4d4d4d5_2d26314c_db135345_01010101;
  localparam logic [127:0] ID_IN  = 128'h01010101_01010101_01010101_01010101;

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic drive(input int sel, input logic st, input logic [127:0] d);
    if (sel == 1) begin
      if_l1.start = st; if_l1.state_in = d;
    end else begin
      if_l4.start = st; if_l4.state_in = d;
    end
  endtask

  function automatic logic done_of(input int sel);
    return (sel == 1) ? if_l1.done : if_l4.done;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel == 1) ? if_l1.busy : if_l4.busy;
  endfunction

  function automatic logic [127:0] out_of(input int sel);
    return (sel == 1) ? if_l1.state_out : if_l4.state_out;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Forward MixColumns, used to build inputs whose inverse is known.
  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] b0, b1, b2, b3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      b0 = s[127 - 8*(4*c)     -: 8];
      b1 = s[127 - 8*(4*c + 1) -: 8];
      b2 = s[127 - 8*(4*c + 2) -: 8];
      b3 = s[127 - 8*(4*c + 3) -: 8];
      o[127 - 8*(4*c)     -: 8] = xt(b0) ^ xt(b1) ^ b1 ^ b2 ^ b3;
      o[127 - 8*(4*c + 1) -: 8] = b0 ^ xt(b1) ^ xt(b2) ^ b2 ^ b3;
      o[127 - 8*(4*c + 2) -: 8] = b0 ^ b1 ^ xt(b2) ^ xt(b3) ^ b3;
      o[127 - 8*(4*c + 3) -: 8] = xt(b0) ^ b0 ^ b1 ^ b2 ^ xt(b3);
    end
    return o;
  endfunction

  // cyc counts cycles inclusively: the cycle start is presented is 1.
  task automatic run_op(input int sel, input logic [127:0] din,
                        output logic [127:0] dout, output int cyc);
    bit seen;
    seen = 1'b0;
    dout = '0;
    @(negedge clk);
    drive(sel, 1'b1, din);
    cyc = 1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      cyc++;
      drive(sel, 1'b0, din);
      if (done_of(sel)) begin
        seen = 1'b1;
        dout = out_of(sel);
      end
    end
    if (!seen) check("op_timeout", 128'(seen), 128'd1);
    $display("op lanes=%0d in=%h out=%h cycles=%0d", (sel == 1) ? 1 : 4, din, dout, cyc);
  endtask

  logic [127:0] res, out1, out2, x;
  int cyc, n, d1, d2, low, n_done;

  initial begin
    rst = 1'b1;
    drive(1, 1'b0, '0);
    drive(4, 1'b0, '0);
    repeat (3) @(negedge clk);
    check("reset_out_l1", if_l1.state_out, '0);
    check("reset_flags_l1", 128'({if_l1.busy, if_l1.done}), '0);
    check("reset_out_l4", if_l4.state_out, '0);
    rst = 1'b0;

    // Abort mid-RUN with rst held 3 cycles.
    @(negedge clk);
    drive(1, 1'b1, V2_IN);
    @(negedge clk);
    drive(1, 1'b0, V2_IN);
    repeat (4) @(negedge clk);
    check("midrun_busy", 128'(if_l1.busy), 128'd1);
    rst = 1'b1;
    #1;
    check("rst_async_out", if_l1.state_out, '0);
    check("rst_async_busy", 128'(if_l1.busy), '0);
    n_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (if_l1.done) n_done++;
    end
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (if_l1.done) n_done++;
    end
    check("rst_no_done", 128'(n_done), '0);
    check("rst_idle_flags", 128'({if_l1.busy, if_l1.done}), '0);
    check("rst_idle_out", if_l1.state_out, '0);
    $display("reset abort: done pulses=%0d", n_done);

    run_op(1, V1_IN, res, cyc);
    check("l1_v1_out", res, V1_OUT);
    check("l1_v1_latency", 128'(cyc), 128'd18);
    repeat (3) @(negedge clk);
    check("l1_hold_out", if_l1.state_out, V1_OUT);

    run_op(4, V2_IN, res, cyc);
    check("l4_v2_out", res, V2_OUT);
    check("l4_v2_latency", 128'(cyc), 128'd6);

    run_op(1, '0, res, cyc);
    check("l1_zero", res, '0);
    run_op(4, ID_IN, res, cyc);
    check("l4_ident", res, ID_IN);
    run_op(4, V1_IN, res, cyc);
    check("l4_v1_out", res, V1_OUT);

    // Start pulse and state_in change while busy must be ignored.
    @(negedge clk);
    drive(1, 1'b1, V1_IN);
    @(negedge clk);
    drive(1, 1'b0, V1_IN);
    repeat (3) @(negedge clk);
    drive(1, 1'b1, {128{1'b1}});
    @(negedge clk);
    drive(1, 1'b0, {128{1'b1}});
    n_done = 0;
    out1 = '0;
    repeat (40) begin
      @(negedge clk);
      if (if_l1.done) begin
        n_done++;
        out1 = if_l1.state_out;
      end
    end
    check("busy_prot_out", out1, V1_OUT);
    check("busy_prot_ndone", 128'(n_done), 128'd1);
    $display("busy protect: out=%h done pulses=%0d", out1, n_done);

    // Back-to-back with start held high.
    @(negedge clk);
    drive(1, 1'b1, V1_IN);
    n = 1; d1 = 0; d2 = 0; low = 0;
    out1 = '0; out2 = '0;
    for (int i = 0; i < 80 && d2 == 0; i++) begin
      @(negedge clk);
      n++;
      if (d1 != 0 && !busy_of(1)) low++;
      if (done_of(1)) begin
        if (d1 == 0) begin
          d1 = n; out1 = out_of(1); drive(1, 1'b1, V2_IN);
        end else begin
          d2 = n; out2 = out_of(1); drive(1, 1'b0, V2_IN);
        end
      end
    end
    check("b2b_out1", out1, V1_OUT);
    check("b2b_out2", out2, V2_OUT);
    check("b2b_first_latency", 128'(d1), 128'd18);
    check("b2b_period", 128'(d2 - d1), 128'd18);
    check("b2b_busy_low", 128'(low), 128'd1);
    $display("back-to-back: done at %0d and %0d, busy low %0d", d1, d2, low);

    for (int i = 0; i < 100; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      run_op(1, mix_cols(x), res, cyc);
      check("rand_l1", res, x);
      x = {$urandom, $urandom, $urandom, $urandom};
      run_op(4, mix_cols(x), res, cyc);
      check("rand_l4", res, x);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
